alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational alu between two requesters (e.g. execute lane and
//  address/branch helper) using valid/ready handshakes and round-robin arbitration.
//  Drives alu inputs from the granted requester and registers alu result_o in a
//  one-entry response buffer with a requester id and tag. Sits between decode/issue and writeback.
// PARAMETERS
//  TAG_W     4    width of the opaque per-request tag returned with the result
//  CNT_W     16   width of the accepted-operation counter
// PORTS
//  clk_i           in   1         clock, all state on rising edge
//  rst_i           in   1         synchronous reset, active-high
//  flush_i         in   1         synchronous flush: discard held response, accept nothing this cycle
//  req_valid_i     in   2         request valid, bit k = requester k
//  req_ready_o     out  2         request accepted this cycle when valid&ready, bit k = requester k
//  req_data1_i     in   64        operand 1, requester k at [32k+31:32k]
//  req_data2_i     in   64        operand 2, requester k at [32k+31:32k]
//  req_opcode_i    in   14        opcode, requester k at [7k+6:7k]
//  req_func3_i     in   6         func3, requester k at [3k+2:3k]
//  req_func7_i     in   14        func7, requester k at [7k+6:7k]
//  req_tag_i       in   2*TAG_W   tag, requester k at [TAG_W*k +: TAG_W]
//  resp_valid_o    out  1         response buffer holds a result
//  resp_ready_i    in   1         consumer takes response when valid&ready
//  resp_result_o   out  32        registered alu result
//  resp_id_o       out  1         requester index that produced resp_result_o
//  resp_tag_o      out  TAG_W     tag of that request
//  op_count_o      out  CNT_W     number of accepted requests, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - One alu instance (alu: data1_i,data2_i,opcode_i,func3_i,func7_i -> result_o), inputs muxed by grant.
//  - States: EMPTY (no response held), FULL (response held). Reset -> EMPTY.
//  - accept_en = !flush_i && (EMPTY || (FULL && resp_ready_i)); allows back-to-back ops, 1/cycle.
//  - Grant: only one valid -> it; both valid -> requester != last_grant; none -> no grant.
//  - req_ready_o[k] = accept_en && grant==k; ready is never high for a non-valid requester.
//  - last_grant updates only on an accepted transfer; reset value 1 so requester 0 wins first tie.
//  - Accept in cycle N: alu result, id, tag registered at edge ending N; resp_valid_o=1 in N+1.
//    Latency exactly 1 cycle; requester operands need only be stable in the accepting cycle.
//  - FULL && resp_ready_i && accept: old response consumed, new one loaded, stays FULL.
//  - FULL && resp_ready_i && no accept -> EMPTY. FULL && !resp_ready_i: outputs held stable.
//  - EMPTY && accept -> FULL. EMPTY && no accept -> EMPTY.
//  - flush_i=1: next state EMPTY regardless of resp_ready_i; no request accepted; last_grant
//    and op_count_o unchanged. Flush overrides a same-cycle consume (no transfer counted).
//  - op_count_o increments by 1 per accepted request, 2^CNT_W-1 -> 0 wrap.
//  - rst_i (sync, also mid-operation): resp_valid_o=0, resp_result_o=0, resp_id_o=0,
//    resp_tag_o=0, op_count_o=0, last_grant=1, state EMPTY; req_ready_o=0 during reset.
//  - No combinational path from resp_ready_i to resp_* outputs; req_ready_o depends on resp_ready_i.
//  - Starvation-free: with both valid continuously and resp_ready_i=1, grants strictly alternate.
// TESTING
//  1 Req0 ADD (opc 0110011,f3 000,f7 0) d1=6,d2=5,tag=3, resp_ready=1 -> next cycle
//    resp_valid=1,result=11,id=0,tag=3; op_count=1.
//  2 Req1 SUB (f7 0100000,f3 000) d1=6,d2=5 alone -> result=1,id=1; req0 idle gets no ready.
//  3 Both valid for 4 cycles after reset, resp_ready=1 -> grants 0,1,0,1; op_count=4.
//  4 Accept ADD, then resp_ready=0 for 3 cycles with both requests valid -> req_ready=00,
//    result 11 held stable; raise resp_ready -> consumed and next request accepted same cycle.
//  5 FULL with resp_ready=1 and flush_i=1, req0 valid -> resp_valid=0 next cycle, req0 not
//    accepted, op_count unchanged; following cycle req0 accepted normally.
//  6 rst_i asserted while FULL and op_count=0xFFFF -> all outputs 0 next cycle; separately
//    0xFFFF + one accept -> op_count=0x0000.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Request/response bundle between two issue requesters, the
//                shared-alu arbiter and the writeback consumer.
//                Requester k occupies slice k of each packed request field.
//  Ports       : req_valid_i/req_ready_o     request handshake, 1 bit per requester
//                req_data1_i/req_data2_i     operands, 32 bits per requester
//                req_opcode_i/req_func7_i    7 bits per requester
//                req_func3_i                 3 bits per requester
//                req_tag_i                   TAG_W bits per requester
//                resp_valid_o/resp_ready_i   response handshake
//                resp_result_o/id/tag        registered response payload
//                op_count_o                  accepted-request counter
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) ();
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [63:0]        req_data1_i;
  logic [63:0]        req_data2_i;
  logic [13:0]        req_opcode_i;
  logic [5:0]         req_func3_i;
  logic [13:0]        req_func7_i;
  logic [2*TAG_W-1:0] req_tag_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [31:0]        resp_result_o;
  logic               resp_id_o;
  logic [TAG_W-1:0]   resp_tag_o;
  logic [CNT_W-1:0]   op_count_o;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_data1_i, req_data2_i, req_opcode_i,
           req_func3_i, req_func7_i, req_tag_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_id_o,
           resp_tag_o, op_count_o
  );

  // Requester / consumer side
  modport master (
    output req_valid_i, req_data1_i, req_data2_i, req_opcode_i,
           req_func3_i, req_func7_i, req_tag_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_id_o,
           resp_tag_o, op_count_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational alu between two requesters with
//                round-robin arbitration and valid/ready handshakes. The alu
//                result of the granted request is captured, with requester id
//                and tag, in a one-entry response buffer (1-cycle latency).
//  Ports       : clk_i    clock, rising edge
//                rst_i    synchronous reset, active-high
//                flush_i  drop held response, accept nothing this cycle
//                bus      alu_arbiter_if.slave request/response bundle
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  input  wire logic     flush_i,
  alu_arbiter_if.slave  bus
);

  localparam logic [6:0] c_opc_op    = 7'b0110011;
  localparam logic [6:0] c_opc_opimm = 7'b0010011;
  localparam logic [6:0] c_opc_lui   = 7'b0110111;
  localparam logic [6:0] c_f7_alt    = 7'b0100000;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_result;
  logic               r_id;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_count;
  logic               r_last_grant;

  logic               w_any_valid;
  logic               w_grant;
  logic               w_accept_en;
  logic [1:0]         w_req_ready;
  logic               w_accept;

  logic [31:0]        w_d1;
  logic [31:0]        w_d2;
  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic [TAG_W-1:0]   w_tag;
  logic [4:0]         w_shamt;
  logic               w_alt;
  logic [31:0]        w_alu_result;

  // --------------------------------------------------------------------------
  // Arbitration. On a tie the requester that did not win last time gets the
  // grant; with a single valid requester it wins outright. A buffered response
  // can be replaced in the same cycle it is consumed, so back-to-back ops run
  // at one per cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_valid = |bus.req_valid_i;
    if (&bus.req_valid_i) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = bus.req_valid_i[1];
    end
    w_accept_en = !rst_i && !flush_i &&
                  ((r_state == ST_EMPTY) || bus.resp_ready_i);
    w_req_ready = {2{w_accept_en && w_any_valid}} & {w_grant, ~w_grant};
    w_accept    = |w_req_ready;
  end

  assign bus.req_ready_o = w_req_ready;

  // Operand mux from the granted requester
  always_comb begin
    if (w_grant) begin
      w_d1  = bus.req_data1_i[63:32];
      w_d2  = bus.req_data2_i[63:32];
      w_opc = bus.req_opcode_i[13:7];
      w_f3  = bus.req_func3_i[5:3];
      w_f7  = bus.req_func7_i[13:7];
      w_tag = bus.req_tag_i[2*TAG_W-1:TAG_W];
    end else begin
      w_d1  = bus.req_data1_i[31:0];
      w_d2  = bus.req_data2_i[31:0];
      w_opc = bus.req_opcode_i[6:0];
      w_f3  = bus.req_func3_i[2:0];
      w_f7  = bus.req_func7_i[6:0];
      w_tag = bus.req_tag_i[TAG_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // The shared alu. Register and immediate forms share decoding; for the
  // immediate form data2 already carries the immediate and func7 carries
  // imm[11:5], which only matters for the arithmetic right shift. Anything not
  // an ALU op (loads, stores, branches, auipc) is an address add.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shamt      = w_d2[4:0];
    w_alt        = (w_f7 == c_f7_alt);
    w_alu_result = w_d1 + w_d2;
    if ((w_opc == c_opc_op) || (w_opc == c_opc_opimm)) begin
      case (w_f3)
        3'b000:  w_alu_result = ((w_opc == c_opc_op) && w_alt) ? (w_d1 - w_d2)
                                                                : (w_d1 + w_d2);
        3'b001:  w_alu_result = w_d1 << w_shamt;
        3'b010:  w_alu_result = {31'd0, ($signed(w_d1) < $signed(w_d2))};
        3'b011:  w_alu_result = {31'd0, (w_d1 < w_d2)};
        3'b100:  w_alu_result = w_d1 ^ w_d2;
        3'b101:  w_alu_result = w_alt ? $unsigned($signed(w_d1) >>> w_shamt)
                                      : (w_d1 >> w_shamt);
        3'b110:  w_alu_result = w_d1 | w_d2;
        default: w_alu_result = w_d1 & w_d2;
      endcase
    end else if (w_opc == c_opc_lui) begin
      w_alu_result = w_d2;
    end
  end

  // --------------------------------------------------------------------------
  // Response buffer FSM. Flush wins over a same-cycle consume or accept and
  // leaves the grant history and counter untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_EMPTY;
      r_result     <= '0;
      r_id         <= 1'b0;
      r_tag        <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state      <= ST_FULL;
      r_result     <= w_alu_result;
      r_id         <= w_grant;
      r_tag        <= w_tag;
      r_count      <= r_count + CNT_W'(1);
      r_last_grant <= w_grant;
    end else if ((r_state == ST_FULL) && bus.resp_ready_i) begin
      r_state <= ST_EMPTY;
    end
  end

  assign bus.resp_valid_o  = (r_state == ST_FULL);
  assign bus.resp_result_o = r_result;
  assign bus.resp_id_o     = r_id;
  assign bus.resp_tag_o    = r_tag;
  assign bus.op_count_o    = r_count;

endmodule
`default_nettype wire
